// File: rtl/filter_pipe.sv
// filter_pipe: 3-stage per-pixel colour filter (pass/sepia/invert/gray/threshold), frame-synchronous mode switch.
// Threshold mode and its carry registers exist only when FILTER_THRESHOLD_EN is defined.
module filter_pipe #(
  parameter int CW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            in_sof,
  input  logic [3*CW-1:0] rgb_in,
  input  logic            sel_valid,
  input  logic [2:0]      sel_mode,
  input  logic [CW-1:0]   thresh,
  output logic            out_valid,
  output logic            out_sof,
  output logic [3*CW-1:0] rgb_out,
  output logic [2:0]      active_mode,
  output logic            sel_err
);
  localparam logic [95:0] K = {8'd101, 8'd197, 8'd48, 8'd89, 8'd176, 8'd43,
                               8'd70, 8'd137, 8'd34, 8'd77, 8'd150, 8'd29};
`ifdef FILTER_THRESHOLD_EN
  localparam logic [2:0] MAX_MODE = 3'd4;
`else
  localparam logic [2:0] MAX_MODE = 3'd3;
`endif
  logic [2:0] pending_q, pending_d, active_q, active_d, mode1_q, mode2_q;
  logic sof_acc, legal, sel_err_q;
  logic v1_q, v2_q, v3_q, sof1_q, sof2_q, sof3_q;
  logic [3*CW-1:0] pix1_q, pix2_q, rgb_q, rgb_d;
  logic [CW+7:0] p_d [12];
  logic [CW+7:0] p_q [12];
  logic [CW+9:0] s_d [4];
  logic [CW+9:0] s_q [4];
  logic [CW-1:0] sat [4];
  logic unused_bits;
  always_comb begin
    legal = sel_mode <= MAX_MODE;
    pending_d = (sel_valid && legal) ? sel_mode : pending_q;
    sof_acc = in_valid && in_sof;
    active_d = sof_acc ? pending_d : active_q;
  end
  // products 0-8 are the sepia rows, 9-11 the luma row; channel order R,G,B
  for (genvar i = 0; i < 12; i++) begin : g_p
    assign p_d[i] = (CW+8)'(rgb_in[(2-i%3)*CW +: CW]) * (CW+8)'(K[95-8*i -: 8]);
  end
  for (genvar j = 0; j < 4; j++) begin : g_s
    assign s_d[j] = (CW+10)'(p_q[3*j]) + (CW+10)'(p_q[3*j+1]) + (CW+10)'(p_q[3*j+2]);
    assign sat[j] = |s_q[j][CW+9:CW+8] ? {CW{1'b1}} : s_q[j][CW+7:8];
  end
`ifdef FILTER_THRESHOLD_EN
  logic [CW-1:0] thr_q, thr1_q, thr2_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      thr_q <= '0;
      thr1_q <= '0;
      thr2_q <= '0;
    end else begin
      thr_q <= sof_acc ? thresh : thr_q;
      thr1_q <= sof_acc ? thresh : thr_q;
      thr2_q <= thr1_q;
    end
  end
  assign unused_bits = ^{s_q[0][7:0], s_q[1][7:0], s_q[2][7:0], s_q[3][7:0]};
`else
  assign unused_bits = ^{s_q[0][7:0], s_q[1][7:0], s_q[2][7:0], s_q[3][7:0], thresh};
`endif
  always_comb begin
    rgb_d = (mode2_q == 3'd1) ? {sat[0], sat[1], sat[2]} :
            (mode2_q == 3'd2) ? ~pix2_q :
            (mode2_q == 3'd3) ? {3{sat[3]}} :
`ifdef FILTER_THRESHOLD_EN
            (mode2_q == 3'd4) ? {3*CW{sat[3] >= thr2_q}} :
`endif
            pix2_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      active_q <= '0;
      sel_err_q <= 1'b0;
      {v1_q, v2_q, v3_q, sof1_q, sof2_q, sof3_q} <= '0;
      mode1_q <= '0;
      mode2_q <= '0;
      pix1_q <= '0;
      pix2_q <= '0;
      rgb_q <= '0;
      p_q <= '{default: '0};
      s_q <= '{default: '0};
    end else begin
      pending_q <= pending_d;
      active_q <= active_d;
      sel_err_q <= sel_valid && !legal;
      v1_q <= in_valid;
      sof1_q <= sof_acc;
      mode1_q <= active_d;
      pix1_q <= rgb_in;
      p_q <= p_d;
      v2_q <= v1_q;
      sof2_q <= sof1_q;
      mode2_q <= mode1_q;
      pix2_q <= pix1_q;
      s_q <= s_d;
      v3_q <= v2_q;
      sof3_q <= sof2_q;
      rgb_q <= v2_q ? rgb_d : rgb_q;
    end
  end
  assign out_valid = v3_q;
  assign out_sof = sof3_q;
  assign rgb_out = rgb_q;
  assign active_mode = active_q;
  assign sel_err = sel_err_q;
endmodule

// File: tb/tb_filter_pipe.sv
// tb_filter_pipe: directed vectors with hand-computed results for filter_pipe (CW=8).
module tb_filter_pipe;
  logic clk = 1'b0;
  logic rst, in_valid, in_sof, sel_valid, out_valid, out_sof, sel_err;
  logic [23:0] rgb_in, rgb_out;
  logic [2:0] sel_mode, active_mode;
  logic [7:0] thresh;
  int checks = 0;
  int failures = 0;
  logic [23:0] oq[$];
  logic sq[$];

  filter_pipe #(.CW(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .rgb_in(rgb_in),
    .sel_valid(sel_valid), .sel_mode(sel_mode), .thresh(thresh),
    .out_valid(out_valid), .out_sof(out_sof), .rgb_out(rgb_out),
    .active_mode(active_mode), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (out_valid) begin
    oq.push_back(rgb_out);
    sq.push_back(out_sof);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [23:0] c3(input int r, input int g, input int b);
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic px(input logic sof, input logic [23:0] p);
    in_valid = 1'b1;
    in_sof = sof;
    rgb_in = p;
    @(negedge clk);
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  task automatic sel(input logic [2:0] m);
    sel_valid = 1'b1;
    sel_mode = m;
    @(negedge clk);
    sel_valid = 1'b0;
  endtask

  task automatic expect_px(input string tag, input logic [23:0] p, input logic s);
    int n = 0;
    while (oq.size() == 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (oq.size() == 0) check({tag, "_timeout"}, 32'd0, 32'd1);
    else begin
      check(tag, oq.pop_front(), p);
      check({tag, "_sof"}, sq.pop_front(), s);
    end
  endtask

  initial begin
    rst = 1'b0;
    in_valid = 1'b0;
    in_sof = 1'b0;
    rgb_in = '0;
    sel_valid = 1'b0;
    sel_mode = '0;
    thresh = '0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_sof", out_sof, 0);
    check("rst_rgb", rgb_out, 0);
    check("rst_mode", active_mode, 0);
    check("rst_err", sel_err, 0);
    rst = 1'b0;
    @(negedge clk);
    px(1'b0, c3(1, 2, 3));
    expect_px("pass0", c3(1, 2, 3), 1'b0);
    // invert frame, with exact latency probe
    sel(3'd2);
    check("pend_no_apply", active_mode, 0);
    px(1'b1, c3(10, 20, 30));
    check("mode_inv", active_mode, 2);
    @(negedge clk);
    check("lat_2", out_valid, 0);
    @(negedge clk);
    check("lat_3", out_valid, 1);
    check("lat_3_sof", out_sof, 1);
    px(1'b0, c3(0, 0, 255));
    expect_px("inv0", c3(245, 235, 225), 1'b1);
    expect_px("inv1", c3(255, 255, 0), 1'b0);
    // sepia with saturation on R and G only
    sel(3'd1);
    px(1'b1, c3(100, 50, 20));
    px(1'b0, c3(255, 255, 255));
    expect_px("sep0", c3(81, 72, 56), 1'b1);
    expect_px("sep1", c3(255, 255, 240), 1'b0);
    sel(3'd3);
    px(1'b1, c3(100, 50, 20));
    expect_px("gray", c3(61, 61, 61), 1'b1);
`ifdef FILTER_THRESHOLD_EN
    thresh = 8'd61;
    sel(3'd4);
    px(1'b1, c3(100, 50, 20));
    check("mode_thr", active_mode, 4);
    expect_px("thr_hi", c3(255, 255, 255), 1'b1);
    thresh = 8'd62;
    px(1'b1, c3(100, 50, 20));
    expect_px("thr_lo", c3(0, 0, 0), 1'b1);
`endif
    // mid-frame select must wait for the next SOF
    sel(3'd0);
    px(1'b1, c3(10, 20, 30));
    expect_px("mid_pass0", c3(10, 20, 30), 1'b1);
    sel(3'd2);
    px(1'b0, c3(10, 20, 30));
    expect_px("mid_pass1", c3(10, 20, 30), 1'b0);
    px(1'b1, c3(10, 20, 30));
    expect_px("mid_inv", c3(245, 235, 225), 1'b1);
    // select coincident with SOF takes effect on that pixel
    sel_valid = 1'b1;
    sel_mode = 3'd1;
    px(1'b1, c3(100, 50, 20));
    sel_valid = 1'b0;
    expect_px("bypass_sep", c3(81, 72, 56), 1'b1);
    sel(3'd2);
    px(1'b0, c3(100, 50, 20));
    px(1'b1, c3(100, 50, 20));
    px(1'b0, c3(0, 0, 0));
    expect_px("cont_sep", c3(81, 72, 56), 1'b0);
    expect_px("cont_inv0", c3(155, 205, 235), 1'b1);
    expect_px("cont_inv1", c3(255, 255, 255), 1'b0);
    // illegal codes
    sel(3'd6);
    check("err6_pulse", sel_err, 1);
    @(negedge clk);
    check("err6_clear", sel_err, 0);
`ifndef FILTER_THRESHOLD_EN
    sel(3'd4);
    check("err4_pulse", sel_err, 1);
`endif
    px(1'b1, c3(10, 20, 30));
    check("err_mode_kept", active_mode, 2);
    expect_px("err_inv", c3(245, 235, 225), 1'b1);
    repeat (4) @(negedge clk);
    check("drained", oq.size(), 0);
    // reset with three pixels in flight
    px(1'b1, c3(1, 1, 1));
    px(1'b0, c3(2, 2, 2));
    px(1'b0, c3(3, 3, 3));
    #2 rst = 1'b1;
    #1 check("rst_drop", out_valid, 0);
    check("rst_first_only", oq.size(), 1);
    oq.delete();
    sq.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("no_stale", oq.size(), 0);
    check("post_rst_mode", active_mode, 0);
    px(1'b0, c3(10, 20, 30));
    expect_px("post_rst_pass", c3(10, 20, 30), 1'b0);
    px(1'b1, c3(10, 20, 30));
    expect_px("post_rst_sof", c3(10, 20, 30), 1'b1);
    check("post_rst_mode2", active_mode, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
